// File: rtl/max7219_chain_ctrl.sv
// ----------------------------------------------------------------------------
// max7219_chain_ctrl
//
// Drives a chain of N_DEV cascaded MAX7219 LED drivers over a 3-wire serial
// bus (LOAD/CS, DIN, SCK). After reset the controller sends the register
// init sequence. It then sits in IDLE and accepts whole-display updates on a
// valid/ready handshake. Each update becomes 9 frames: one intensity frame,
// then one frame per digit.
//
// SCK is a registered data output toggled from a clk-enable style divider.
// It is never used as a clock inside this block.
//
// Frame timing, with T = CLK_DIV and NB = 16*N_DEV:
//   cycle 0            : cs_n low, din = MSB, sck low
//   bit i              : sck high over [(2i+1)T, (2i+2)T), din moves on fall
//   cycle (2NB+1)T     : cs_n high, din low
//   cycles up to +2T   : cs_n held high before the next frame may start
//
// Optional build macro:
//   MAX7219_HEX_DECODE_EN - each digit byte is {dp, 3'bx, nibble}. The nibble
//   is mapped through a hex-to-7-segment table when the frame is loaded.
//   When the macro is undefined, bytes are sent as raw segment patterns.
//   The device decode-mode register is programmed to 00 in both builds.
// ----------------------------------------------------------------------------
module max7219_chain_ctrl #(
  parameter int N_DEV      = 1,
  parameter int CLK_DIV    = 4,
  parameter int SCAN_LIMIT = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [64*N_DEV-1:0]   upd_data,
  input  logic [3:0]            intensity,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_din,
  output logic                  spi_sck
);

  // Frame geometry and counter widths.
  localparam int NB     = 16 * N_DEV;
  localparam int DATA_W = 64 * N_DEV;
  localparam int BW     = $clog2(NB + 1);
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(NB);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Last frame index of each multi-frame sequence.
  localparam logic [3:0] INIT_LAST = 4'd4;
  localparam logic [3:0] UPD_LAST  = 4'd8;

  // Top-level controller states.
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  // Frame engine phases.
  localparam logic [1:0] PH_OFF   = 2'd0;
  localparam logic [1:0] PH_SHIFT = 2'd1;
  localparam logic [1:0] PH_GAP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [1:0]        eng_phase;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              gap_second;
  logic [NB-1:0]     shift_reg;
  logic [3:0]        frame_idx;
  logic [DATA_W-1:0] shadow;

  logic              seg_end;
  logic              frame_done;
  logic              handshake;
  logic              load;
  logic              load_upd;
  logic [3:0]        load_idx;
  logic [NB-1:0]     load_word;

  // Segment-pattern encoding of one digit byte. In the hex build, bits 6:4
  // of the byte are don't-care.
`ifdef MAX7219_HEX_DECODE_EN
  function automatic logic [7:0] seg_encode(input logic [7:0] b);
    logic [6:0] s;
    case (b[3:0])
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return {b[7], s};
  endfunction
`else
  function automatic logic [7:0] seg_encode(input logic [7:0] b);
    return b;
  endfunction
`endif

  // Builds the whole NB-bit frame for one position in the init or update
  // sequence. Device k occupies bits [k*16 +: 16], so the highest device is
  // shifted out first. Command frames repeat the same word for every device.
  function automatic logic [NB-1:0] frame_word(input logic             is_upd,
                                               input logic [3:0]       idx,
                                               input logic [3:0]       inten,
                                               input logic [DATA_W-1:0] data);
    logic [NB-1:0] w;
    logic [7:0]    addr;
    logic [7:0]    val;
    int            dig;
    int            base;
    w    = '0;
    addr = 8'h00;
    val  = 8'h00;
    dig  = int'(idx) - 1;
    if (!is_upd) begin
      case (idx)
        4'd0:    begin addr = 8'h0C; val = 8'h01;           end
        4'd1:    begin addr = 8'h09; val = 8'h00;           end
        4'd2:    begin addr = 8'h0B; val = 8'(SCAN_LIMIT);  end
        4'd3:    begin addr = 8'h0A; val = {4'h0, inten};   end
        default: begin addr = 8'h0F; val = 8'h00;           end
      endcase
    end else if (idx == 4'd0) begin
      addr = 8'h0A;
      val  = {4'h0, inten};
    end else begin
      addr = {4'h0, idx};
    end
    for (int k = 0; k < N_DEV; k++) begin
      if (is_upd && (idx != 4'd0)) begin
        base = (k * 8 + dig) * 8;
        w[k*16 +: 16] = {addr, seg_encode(data[base +: 8])};
      end else begin
        w[k*16 +: 16] = {addr, val};
      end
    end
    return w;
  endfunction

  assign load_word = frame_word(load_upd, load_idx, intensity, shadow);

  // Sequencer decisions. Each new frame is loaded on the same edge that ends
  // the previous frame's gap, so back-to-back frames have no extra cycle.
  always_comb begin
    seg_end    = (div_cnt == DIV_LAST);
    frame_done = (eng_phase == PH_GAP) && seg_end && gap_second;
    handshake  = upd_valid && upd_ready;
    next_state = state;
    load       = 1'b0;
    load_upd   = 1'b0;
    load_idx   = 4'd0;
    case (state)
      ST_INIT: begin
        if (eng_phase == PH_OFF) begin
          load = 1'b1;
        end else if (frame_done) begin
          if (frame_idx == INIT_LAST) begin
            next_state = ST_IDLE;
          end else begin
            load     = 1'b1;
            load_idx = frame_idx + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (handshake) begin
          next_state = ST_UPDATE;
          load       = 1'b1;
          load_upd   = 1'b1;
        end
      end
      ST_UPDATE: begin
        load_upd = 1'b1;
        if (eng_phase == PH_OFF) begin
          next_state = ST_IDLE;
        end else if (frame_done) begin
          if (frame_idx == UPD_LAST) begin
            next_state = ST_IDLE;
          end else begin
            load     = 1'b1;
            load_idx = frame_idx + 4'd1;
          end
        end
      end
      default: next_state = ST_INIT;
    endcase
  end

  // Controller state, handshake outputs and the shadow copy of the display.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_INIT;
      busy      <= 1'b1;
      upd_ready <= 1'b0;
      shadow    <= '0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != ST_IDLE);
      upd_ready <= (next_state == ST_IDLE);
      if (handshake) begin
        shadow <= upd_data;
      end
    end
  end

  // Frame engine: divides clk into T-cycle segments, toggles SCK, and shifts
  // out the frame MSB first, then holds cs_n high for two gap segments.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eng_phase  <= PH_OFF;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_second <= 1'b0;
      shift_reg  <= '0;
      frame_idx  <= 4'd0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_din    <= 1'b0;
    end else if (load) begin
      eng_phase  <= PH_SHIFT;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_second <= 1'b0;
      shift_reg  <= load_word;
      frame_idx  <= load_idx;
      spi_cs_n   <= 1'b0;
      spi_sck    <= 1'b0;
      spi_din    <= load_word[NB-1];
    end else begin
      case (eng_phase)
        PH_SHIFT: begin
          div_cnt <= seg_end ? '0 : div_cnt + DW'(1);
          if (seg_end) begin
            if (spi_sck) begin
              spi_sck   <= 1'b0;
              shift_reg <= {shift_reg[NB-2:0], 1'b0};
              spi_din   <= shift_reg[NB-2];
              bit_cnt   <= bit_cnt + BW'(1);
            end else if (bit_cnt == BIT_LAST) begin
              spi_cs_n   <= 1'b1;
              spi_din    <= 1'b0;
              eng_phase  <= PH_GAP;
              gap_second <= 1'b0;
            end else begin
              spi_sck <= 1'b1;
            end
          end
        end
        PH_GAP: begin
          div_cnt <= seg_end ? '0 : div_cnt + DW'(1);
          if (seg_end) begin
            if (gap_second) begin
              eng_phase <= PH_OFF;
            end else begin
              gap_second <= 1'b1;
            end
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule
